// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start bit, 8 data + odd parity + stop, device ACK.
// Latency: about 120 us of inhibit, then 11 device clocks, then a one-cycle done or error pulse.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored everywhere else.

// Glitch filter for one raw PS/2 line: 2-FF synchronizer followed by a 16-cycle stability filter.
// Latency: 2 sync cycles plus 16 stable cycles before the filtered output follows a new level.
// Backpressure: none, free-running.
module ps2_line_filter (
    input  logic clk28,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    logic       sync_1;
    logic       sync_2;
    logic [3:0] stable_cnt;

    // Synchronize the raw line; adopt a new level only after 16 consecutive differing cycles.
    always_ff @(posedge clk28) begin
        if (rst) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            filt       <= 1'b1;
            stable_cnt <= 4'd0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == filt) begin
                stable_cnt <= 4'd0;
            end else if (stable_cnt == 4'd15) begin
                filt       <= sync_2;
                stable_cnt <= 4'd0;
            end else begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

endmodule

// PS/2 host transmitter top: request-to-send sequencing, bit shifting on device clock falls, timeouts.
// Latency: inhibit T_INH cycles, then paced by the device clock; result pulse one cycle after the deciding event.
// Backpressure: single-byte, tx_ready = IDLE and not in reset; no queueing.
module ps2_host_tx #(
    parameter int CLK_FREQ = 28_000_000
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       error,
    output logic       rx_inhibit
);

    // Timing constants, computed in 64 bits so large clock rates cannot overflow.
    localparam longint FREQ_L      = longint'(CLK_FREQ);
    localparam int     T_INH       = int'(FREQ_L * 120 / 1_000_000);
    localparam int     T_FIRST     = int'(FREQ_L * 15 / 1000);
    localparam int     T_ACK       = int'(FREQ_L * 2 / 1000);
    localparam int     T_WAIT      = int'(FREQ_L / 1000);
    // Start bit goes low 160 cycles before the clock is released (clamped for very slow clocks).
    localparam int     T_START_RAW = T_INH - 160;
    localparam int     T_START     = (T_START_RAW > 0) ? T_START_RAW : 0;

    // Timer wide enough for the longest window, never narrower than 19 bits.
    localparam int     TW_NEED     = $clog2(T_FIRST + 1);
    localparam int     TW          = (TW_NEED > 19) ? TW_NEED : 19;

    localparam logic [TW-1:0] INH_LAST   = TW'(T_INH - 1);
    localparam logic [TW-1:0] START_CNT  = TW'(T_START);
    localparam logic [TW-1:0] FIRST_LAST = TW'(T_FIRST - 1);
    localparam logic [TW-1:0] ACK_LAST   = TW'(T_ACK - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(T_WAIT - 1);
    localparam logic          START_AT_ACCEPT = (T_START == 0);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_inc;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          clk_filt;
    logic          dat_filt;
    logic          clk_filt_prev;
    logic          dev_fall;
    logic          tx_bit;
    logic          send_timeout;

    ps2_line_filter u_clk_filt (
        .clk28 (clk28),
        .rst   (rst),
        .raw   (ps2_clk_in),
        .filt  (clk_filt)
    );

    ps2_line_filter u_dat_filt (
        .clk28 (clk28),
        .rst   (rst),
        .raw   (ps2_dat_in),
        .filt  (dat_filt)
    );

    // One-cycle strobe on a filtered device clock 1->0 transition.
    assign dev_fall  = clk_filt_prev & ~clk_filt;
    assign timer_inc = timer_q + 1'b1;

    assign tx_ready   = (state_q == IDLE) && !rst;
    assign rx_inhibit = (state_q != IDLE) && !rst;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign done       = done_q;
    assign error      = err_q;

    // Select the frame bit for the current index: data LSB first, then odd parity, then stop.
    always_comb begin
        tx_bit = 1'b1;
        if (idx_q < 4'd8) begin
            tx_bit = data_q[idx_q[2:0]];
        end else if (idx_q == 4'd8) begin
            tx_bit = par_q;
        end
    end

    // Before the first fall the window runs from clock release; afterwards from the first fall.
    always_comb begin
        send_timeout = (idx_q == 4'd0) ? (timer_q == FIRST_LAST) : (timer_q == ACK_LAST);
    end

    // Next-state and next-output logic; timeouts win over a coincident device clock fall.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        idx_d    = idx_q;
        timer_d  = timer_inc;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d  = '0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_d   = tx_data;
                    par_d    = ~^tx_data;
                    idx_d    = 4'd0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = START_AT_ACCEPT;
                    state_d  = INHIBIT;
                end
            end

            INHIBIT: begin
                clk_oe_d = 1'b1;
                if (timer_q == INH_LAST) begin
                    // Release the clock with the start bit already on the data line.
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    idx_d    = 4'd0;
                    timer_d  = '0;
                    state_d  = SEND;
                end else if (timer_inc >= START_CNT) begin
                    dat_oe_d = 1'b1;
                end
            end

            SEND: begin
                clk_oe_d = 1'b0;
                if (send_timeout) begin
                    dat_oe_d = 1'b0;
                    err_d    = 1'b1;
                    timer_d  = '0;
                    state_d  = IDLE;
                end else if (dev_fall) begin
                    dat_oe_d = ~tx_bit;
                    idx_d    = idx_q + 4'd1;
                    if (idx_q == 4'd0) begin
                        timer_d = '0;
                    end
                    if (idx_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
                end
            end

            ACK: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (timer_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (dev_fall) begin
                    if (!dat_filt) begin
                        timer_d = '0;
                        state_d = WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        timer_d = '0;
                        state_d = IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (timer_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = IDLE;
                end else if (clk_filt && dat_filt) begin
                    done_d  = 1'b1;
                    timer_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                timer_d  = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State, datapath and registered line drivers; reset releases both lines at the next edge.
    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q       <= IDLE;
            data_q        <= 8'h00;
            par_q         <= 1'b0;
            idx_q         <= 4'd0;
            timer_q       <= '0;
            clk_oe_q      <= 1'b0;
            dat_oe_q      <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            clk_filt_prev <= 1'b1;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            par_q         <= par_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            clk_oe_q      <= clk_oe_d;
            dat_oe_q      <= dat_oe_d;
            done_q        <= done_d;
            err_q         <= err_d;
            clk_filt_prev <= clk_filt;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a device clock model.
// The DUT runs at 2 MHz so the 15 ms first-edge timeout stays short; all windows scale with it
// (inhibit 240 cycles, start bit at 80, first-edge timeout 30000; device clock 12.5 kHz = 160 cycles).
module tb_ps2_host_tx;

    localparam int     CLK_FREQ = 2_000_000;
    localparam longint FREQ_L   = CLK_FREQ;
    localparam int     T_INH    = int'(FREQ_L * 120 / 1_000_000);
    localparam int     DAT_AT   = T_INH - 160;
    localparam int     T_FIRST  = int'(FREQ_L * 15 / 1000);
    localparam int     T_ACK    = int'(FREQ_L * 2 / 1000);
    localparam int     T_WAIT   = int'(FREQ_L / 1000);
    localparam int     HALF     = CLK_FREQ / 12_500 / 2;

    logic       clk28 = 1'b0;
    logic       rst;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       error;
    logic       rx_inhibit;

    logic       dev_clk;
    logic       dev_dat;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;

    logic [9:0] frame_q[$];
    logic [1:0] res_q[$];

    always #5 clk28 = ~clk28;

    // Wired-AND bus: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk28      (clk28),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .done       (done),
        .error      (error),
        .rx_inhibit (rx_inhibit)
    );

    // Pulse counters for done/error, sampled away from the active edge.
    always @(negedge clk28) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog: simulation exceeded 200000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk28);
    endtask

    // Count cycles with the clock held low and find when the start bit appears; starts at cycle 0 after accept.
    task automatic watch_inhibit(output int oe_cyc, output int rise);
        int i;
        i    = 0;
        rise = -1;
        while (ps2_clk_oe === 1'b1 && i < T_INH + 50) begin
            if (rise < 0 && ps2_dat_oe === 1'b1) rise = i;
            i++;
            @(negedge clk28);
        end
        oe_cyc = i;
    endtask

    // Device model: generates falls/rises at 12.5 kHz, samples data on each rising edge.
    task automatic dev_run(input int nfall, input bit ack, input bit glitch, input bit stop_low,
                           output logic [9:0] bits);
        bits = '0;
        for (int k = 1; k <= nfall; k++) begin
            if (glitch && k == 3) begin
                cyc(20);
                dev_clk = 1'b0;
                cyc(10);
                dev_clk = 1'b1;
                cyc(HALF - 30);
            end else if (k == 11) begin
                cyc(HALF / 2);
                dev_dat = ack ? 1'b0 : 1'b1;
                cyc(HALF - HALF / 2);
            end else begin
                cyc(HALF);
            end
            dev_clk = 1'b0;
            if (stop_low && k == nfall) begin
                cyc(40);
            end else begin
                cyc(HALF);
                dev_clk = 1'b1;
                if (k <= 10) bits[k-1] = ps2_dat_in;
            end
        end
        if (!stop_low) begin
            cyc(5);
            dev_dat = 1'b1;
        end
    endtask

    // Wait (bounded) for a done or error pulse, let the bus settle, then score it.
    task automatic score_result(input int d0, input int e0);
        int         i;
        logic       seen;
        logic [1:0] er;
        i = 0;
        while ((done_cnt - d0) + (err_cnt - e0) == 0 && i < T_WAIT + T_ACK + 500) begin
            @(negedge clk28);
            i++;
        end
        seen = ((done_cnt - d0) + (err_cnt - e0) != 0);
        chk("result_seen", 32'(seen), 32'd1);
        cyc(50);
        er = res_q.pop_front();
        chk("done_pulses", done_cnt - d0, 32'(er[0]));
        chk("error_pulses", err_cnt - e0, 32'(er[1]));
        chk("idle_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("idle_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("idle_tx_ready", 32'(tx_ready), 32'd1);
    endtask

    // Full transfer: request, inhibit timing, device clocking, frame and result scoring.
    task automatic run_xfer(input logic [7:0] b, input bit ack, input bit glitch);
        int         d0, e0, oe_cyc, rise;
        logic [9:0] bits;
        logic [9:0] ef;
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = b;
        tx_valid = 1'b1;
        chk("ready_at_request", 32'(tx_ready), 32'd1);
        @(negedge clk28);
        tx_valid = 1'b0;
        frame_q.push_back({1'b1, ~^b, b});
        res_q.push_back(ack ? 2'b01 : 2'b10);
        chk("rx_inhibit_busy", 32'(rx_inhibit), 32'd1);
        watch_inhibit(oe_cyc, rise);
        chk("clk_oe_cycles", oe_cyc, T_INH);
        chk("dat_oe_rise", rise, DAT_AT);
        dev_run(11, ack, glitch, 1'b0, bits);
        ef = frame_q.pop_front();
        chk("data_bits", 32'(bits[7:0]), 32'(ef[7:0]));
        chk("parity_bit", 32'(bits[8]), 32'(ef[8]));
        chk("stop_bit", 32'(bits[9]), 32'(ef[9]));
        score_result(d0, e0);
    endtask

    initial begin
        int         d0, e0, i, oe_cyc, rise;
        logic [9:0] bits;

        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        cyc(3);

        // Reset state.
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk28);
        chk("ready_after_rst", 32'(tx_ready), 32'd1);
        cyc(5);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1, acked.
        run_xfer(8'hED, 1'b1, 1'b0);
        cyc(20);

        // Parity sweep.
        run_xfer(8'h00, 1'b1, 1'b0);
        cyc(20);
        run_xfer(8'hFF, 1'b1, 1'b0);
        cyc(20);
        run_xfer(8'h01, 1'b1, 1'b0);
        cyc(20);

        // Device leaves data high at the 11th edge: error, no done.
        run_xfer(8'h96, 1'b0, 1'b0);
        cyc(20);

        // 10-cycle low glitch on the clock during SEND must be filtered out.
        run_xfer(8'h3C, 1'b1, 1'b1);
        cyc(20);

        // No device clocking: first-edge timeout after the inhibit window.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk28);
        tx_valid = 1'b0;
        res_q.push_back(2'b10);
        i = 0;
        while (error !== 1'b1 && i < T_INH + T_FIRST + 200) begin
            @(negedge clk28);
            i++;
        end
        chk_rng("timeout_latency", i, T_INH + T_FIRST - 20, T_INH + T_FIRST + 20);
        chk("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("timeout_tx_ready", 32'(tx_ready), 32'd1);
        score_result(d0, e0);
        cyc(20);

        // Reset after the 4th fall, with tx_valid held (new data) through SEND.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk28);
        tx_data = 8'h5A;
        watch_inhibit(oe_cyc, rise);
        chk("rst_test_clk_oe_cycles", oe_cyc, T_INH);
        dev_run(4, 1'b1, 1'b0, 1'b1, bits);
        chk("held_valid_bits", 32'(bits[2:0]), 32'h5);
        chk("held_valid_ready", 32'(tx_ready), 32'd0);
        chk("held_valid_inhibit", 32'(rx_inhibit), 32'd1);
        rst      = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk28);
        chk("midrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("midrst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("midrst_tx_ready", 32'(tx_ready), 32'd0);
        chk("midrst_rx_inhibit", 32'(rx_inhibit), 32'd0);
        rst     = 1'b0;
        dev_clk = 1'b1;
        @(negedge clk28);
        chk("midrst_ready_after", 32'(tx_ready), 32'd1);
        cyc(200);
        chk("midrst_no_done", done_cnt - d0, 32'd0);
        chk("midrst_no_error", err_cnt - e0, 32'd0);
        chk("midrst_idle_clk_oe", 32'(ps2_clk_oe), 32'd0);

        chk("done_error_together", both_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
